// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h memory responder: FSM encoding,
// parameter defaults and a byte-merge helper for partial word writes.
package jt900h_pkg;

    localparam int CEN_DIV_DEF = 2;
    localparam int TOUT_DEF    = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Replaces only the byte lanes selected by we, keeping the rest of old_word.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_word,
                                                input logic [15:0] new_word,
                                                input logic [1:0]  we);
        return {we[1] ? new_word[15:8] : old_word[15:8],
                we[0] ? new_word[7:0]  : old_word[7:0]};
    endfunction

endpackage

// File: rtl/jt900h_cendiv.sv
// CPU clock-enable divider: one cen pulse every CEN_DIV clocks, counter held
// while freeze is high so the CPU stalls without losing its phase.
module jt900h_cendiv
    import jt900h_pkg::*;
#(
    parameter int CEN_DIV = CEN_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic freeze,
    output logic cen
);

    localparam int            CW   = (CEN_DIV > 2) ? $clog2(CEN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CEN_DIV - 1);

    logic [CW-1:0] cnt;

    // cen rises when the counter wraps, so the first pulse after reset lands
    // exactly CEN_DIV cycles after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            cen <= 1'b0;
        end else if (freeze) begin
            cen <= 1'b0;
        end else begin
            cen <= (cnt == LAST);
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jt900h_memrsp.sv
// Bridges a 16-bit CPU bus onto an 8-bit acknowledged memory bus, with a
// one-word write-through read cache and a per-byte ack timeout.
module jt900h_memrsp
    import jt900h_pkg::*;
#(
    parameter int CEN_DIV = CEN_DIV_DEF,
    parameter int TOUT    = TOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        cpu_cen,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_we,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int            TW    = $clog2(TOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);

    mem_state_t    state;
    logic          slot;
    logic          active;
    logic          tout_seen;
    logic [22:0]   req_word;
    logic [1:0]    req_we;
    logic [15:0]   req_din;
    logic [22:0]   tag;
    logic          valid;
    logic [15:0]   cache;
    logic [7:0]    lo_byte;
    logic [7:0]    hi_byte;
    logic [TW-1:0] tcnt;

    logic [22:0] cpu_word;
    logic        cached;
    logic        hit;
    logic        start;
    logic        freeze;
    logic [7:0]  byte_in;
    logic        unused;

    assign cpu_word = cpu_addr[23:1];
    assign unused   = cpu_addr[0];
    assign cached   = valid && (tag == cpu_word);
    assign hit      = slot && (cpu_we == 2'b00) && cached;
    assign start    = slot && (state == IDLE) && !hit;
    // Freezing already in the sample slot keeps a pulse from slipping out
    // on the very cycle an access is being launched.
    assign freeze   = (state != IDLE) || start;
    assign byte_in  = mem_ack ? mem_rdata : 8'hFF;

    jt900h_cendiv #(
        .CEN_DIV (CEN_DIV)
    ) u_cendiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (freeze),
        .cen    (cpu_cen)
    );

    // Each byte state spends one cycle with the strobe low (active=0) before
    // raising it, so consecutive byte strobes are always separated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot      <= 1'b0;
            active    <= 1'b0;
            tout_seen <= 1'b0;
            req_word  <= '0;
            req_we    <= '0;
            req_din   <= '0;
            tag       <= '0;
            valid     <= 1'b0;
            cache     <= '0;
            lo_byte   <= '0;
            hi_byte   <= '0;
            tcnt      <= '0;
            cpu_dout  <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            slot <= cpu_cen;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (slot) begin
                        req_word <= cpu_word;
                        req_we   <= cpu_we;
                        req_din  <= cpu_din;
                        if (hit) begin
                            cpu_dout <= cache;
                        end else begin
                            state     <= (cpu_we == 2'b00 || cpu_we[0]) ? LO : HI;
                            active    <= 1'b0;
                            tout_seen <= 1'b0;
                        end
                        if (cpu_we != 2'b00 && cached)
                            cache <= merge_bytes(cache, cpu_din, cpu_we);
                    end
                end
                LO, HI: begin
                    if (!active) begin
                        active    <= 1'b1;
                        tcnt      <= '0;
                        mem_addr  <= {req_word, state == HI};
                        mem_rd    <= (req_we == 2'b00);
                        mem_wr    <= (req_we != 2'b00);
                        mem_wdata <= (state == HI) ? req_din[15:8] : req_din[7:0];
                    end else if (mem_ack || tcnt == TLAST) begin
                        active <= 1'b0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (!mem_ack) begin
                            err       <= 1'b1;
                            tout_seen <= 1'b1;
                        end
                        if (state == HI) begin
                            hi_byte <= byte_in;
                            state   <= DONE;
                        end else begin
                            lo_byte <= byte_in;
                            state   <= (req_we == 2'b00 || req_we[1]) ? HI : DONE;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (req_we == 2'b00) begin
                        cpu_dout <= {hi_byte, lo_byte};
                        cache    <= {hi_byte, lo_byte};
                        tag      <= req_word;
                        valid    <= !tout_seen;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
